// File: rtl/sm83_ext_clkgen_if.sv
// Phase-clock and reset-sequencing bundle from the clock generator to the SM83 core.
interface sm83_ext_clkgen_if;
  logic ADR_CLK_P;
  logic ADR_CLK_N;
  logic DATA_CLK_P;
  logic DATA_CLK_N;
  logic INC_CLK_P;
  logic INC_CLK_N;
  logic LATCH_CLK;
  logic MAIN_CLK_P;
  logic MAIN_CLK_N;
  logic CLK_ENA;
  logic OSC_ENA;
  logic OSC_STABLE;
  logic ASYNC_RESET;
  logic SYNC_RESET;

  modport master (
    output ADR_CLK_P, ADR_CLK_N, DATA_CLK_P, DATA_CLK_N, INC_CLK_P, INC_CLK_N,
    output LATCH_CLK, MAIN_CLK_P, MAIN_CLK_N,
    output CLK_ENA, OSC_ENA, OSC_STABLE, ASYNC_RESET, SYNC_RESET
  );

  modport slave (
    input ADR_CLK_P, ADR_CLK_N, DATA_CLK_P, DATA_CLK_N, INC_CLK_P, INC_CLK_N,
    input LATCH_CLK, MAIN_CLK_P, MAIN_CLK_N,
    input CLK_ENA, OSC_ENA, OSC_STABLE, ASYNC_RESET, SYNC_RESET
  );
endinterface

// File: rtl/sm83_ext_clkgen.sv
// SM83 clock/reset sequencer: brings up the oscillator, releases resets in order and
// divides CLK into the core's eight-step phase clocks. Every output is a flop.
module sm83_ext_clkgen #(
  parameter int unsigned OSC_STABLE_CYCLES  = 16,
  parameter int unsigned SYNC_RESET_MCYCLES = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  sm83_ext_clkgen_if.master  clk_if
);

  typedef enum logic [2:0] {
    StIdle,
    StOscOn,
    StOscWait,
    StClkStart,
    StSync,
    StRun
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  ph_q, ph_d;
  logic [7:0]  stab_cnt_q, stab_cnt_d;
  logic [3:0]  sync_cnt_q, sync_cnt_d;
  logic        osc_ena_q, osc_ena_d;
  logic        osc_stable_q, osc_stable_d;
  logic        async_rst_q, async_rst_d;
  logic        sync_rst_q, sync_rst_d;
  logic        clk_ena_q, clk_ena_d;
  // Bit order: {main, inc, data, adr}
  logic [3:0]  phase_p_q, phase_p_d;
  logic [3:0]  phase_n_q, phase_n_d;
  logic        latch_q, latch_d;

  logic stab_done;
  logic sync_done;
  logic ph_wrap;

  assign stab_done = (stab_cnt_q == 8'(OSC_STABLE_CYCLES - 1));
  assign sync_done = (sync_cnt_q == 4'(SYNC_RESET_MCYCLES - 1));
  assign ph_wrap   = (ph_q == 3'd7);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q      <= StIdle;
      ph_q         <= 3'd0;
      stab_cnt_q   <= 8'd0;
      sync_cnt_q   <= 4'd0;
      osc_ena_q    <= 1'b0;
      osc_stable_q <= 1'b0;
      async_rst_q  <= 1'b1;
      sync_rst_q   <= 1'b1;
      clk_ena_q    <= 1'b0;
      phase_p_q    <= 4'b0000;
      phase_n_q    <= 4'b1111;
      latch_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      stab_cnt_q   <= stab_cnt_d;
      sync_cnt_q   <= sync_cnt_d;
      osc_ena_q    <= osc_ena_d;
      osc_stable_q <= osc_stable_d;
      async_rst_q  <= async_rst_d;
      sync_rst_q   <= sync_rst_d;
      clk_ena_q    <= clk_ena_d;
      phase_p_q    <= phase_p_d;
      phase_n_q    <= phase_n_d;
      latch_q      <= latch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     state_d = StOscOn;
      StOscOn:    state_d = StOscWait;
      StOscWait:  if (stab_done) state_d = StClkStart;
      StClkStart: state_d = StSync;
      StSync:     if (ph_wrap && sync_done) state_d = StRun;
      StRun:      state_d = StRun;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    ph_d         = ph_q;
    stab_cnt_d   = stab_cnt_q;
    sync_cnt_d   = sync_cnt_q;
    osc_ena_d    = osc_ena_q;
    osc_stable_d = osc_stable_q;
    async_rst_d  = async_rst_q;
    sync_rst_d   = sync_rst_q;
    clk_ena_d    = clk_ena_q;
    unique case (state_q)
      StIdle: ;
      StOscOn: begin
        osc_ena_d  = 1'b1;
        stab_cnt_d = 8'd0;
      end
      StOscWait: begin
        stab_cnt_d = stab_cnt_q + 8'd1;
        if (stab_done) begin
          osc_stable_d = 1'b1;
          async_rst_d  = 1'b0;
        end
      end
      StClkStart: begin
        clk_ena_d  = 1'b1;
        ph_d       = 3'd0;
        sync_cnt_d = 4'd0;
      end
      StSync: begin
        ph_d = ph_q + 3'd1;
        // Each 7->0 wrap closes one full core cycle
        if (ph_wrap) begin
          sync_cnt_d = sync_cnt_q + 4'd1;
          if (sync_done) sync_rst_d = 1'b0;
        end
      end
      StRun:   ph_d = ph_q + 3'd1;
      default: ;
    endcase

    // Decode from the next phase so the registered outputs line up with ph.
    phase_p_d = 4'b0000;
    latch_d   = 1'b0;
    if (clk_ena_d) begin
      phase_p_d[0] = (ph_d <= 3'd3);
      phase_p_d[1] = (ph_d >= 3'd2) && (ph_d <= 3'd5);
      phase_p_d[2] = (ph_d >= 3'd4);
      phase_p_d[3] = ~ph_d[0];
      latch_d      = (ph_d == 3'd7);
    end
    phase_n_d = ~phase_p_d;
  end

  assign clk_if.ADR_CLK_P   = phase_p_q[0];
  assign clk_if.ADR_CLK_N   = phase_n_q[0];
  assign clk_if.DATA_CLK_P  = phase_p_q[1];
  assign clk_if.DATA_CLK_N  = phase_n_q[1];
  assign clk_if.INC_CLK_P   = phase_p_q[2];
  assign clk_if.INC_CLK_N   = phase_n_q[2];
  assign clk_if.MAIN_CLK_P  = phase_p_q[3];
  assign clk_if.MAIN_CLK_N  = phase_n_q[3];
  assign clk_if.LATCH_CLK   = latch_q;
  assign clk_if.CLK_ENA     = clk_ena_q;
  assign clk_if.OSC_ENA     = osc_ena_q;
  assign clk_if.OSC_STABLE  = osc_stable_q;
  assign clk_if.ASYNC_RESET = async_rst_q;
  assign clk_if.SYNC_RESET  = sync_rst_q;

endmodule

// File: tb/tb_sm83_ext_clkgen.sv
// Directed bench: default-parameter and minimum-parameter instances run side by side.
module tb_sm83_ext_clkgen;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 CLK = ~CLK;

  sm83_ext_clkgen_if if_a ();
  sm83_ext_clkgen_if if_b ();

  sm83_ext_clkgen #(
    .OSC_STABLE_CYCLES (16),
    .SYNC_RESET_MCYCLES(2)
  ) u_dut_a (
    .CLK   (CLK),
    .RESET (RESET),
    .clk_if(if_a)
  );

  sm83_ext_clkgen #(
    .OSC_STABLE_CYCLES (1),
    .SYNC_RESET_MCYCLES(1)
  ) u_dut_b (
    .CLK   (CLK),
    .RESET (RESET),
    .clk_if(if_b)
  );

  // ctrl = {OSC_ENA, OSC_STABLE, ASYNC_RESET, CLK_ENA, SYNC_RESET}
  // phs  = {ADR_P, ADR_N, DATA_P, DATA_N, INC_P, INC_N, LATCH, MAIN_P, MAIN_N}
  logic [4:0] ctrl_a, ctrl_b;
  logic [8:0] phs_a, phs_b;
  assign ctrl_a = {if_a.OSC_ENA, if_a.OSC_STABLE, if_a.ASYNC_RESET, if_a.CLK_ENA, if_a.SYNC_RESET};
  assign ctrl_b = {if_b.OSC_ENA, if_b.OSC_STABLE, if_b.ASYNC_RESET, if_b.CLK_ENA, if_b.SYNC_RESET};
  assign phs_a = {if_a.ADR_CLK_P, if_a.ADR_CLK_N, if_a.DATA_CLK_P, if_a.DATA_CLK_N,
                  if_a.INC_CLK_P, if_a.INC_CLK_N, if_a.LATCH_CLK, if_a.MAIN_CLK_P, if_a.MAIN_CLK_N};
  assign phs_b = {if_b.ADR_CLK_P, if_b.ADR_CLK_N, if_b.DATA_CLK_P, if_b.DATA_CLK_N,
                  if_b.INC_CLK_P, if_b.INC_CLK_N, if_b.LATCH_CLK, if_b.MAIN_CLK_P, if_b.MAIN_CLK_N};

  localparam logic [4:0] CtrlReset = 5'b00101;
  localparam logic [8:0] PhsIdle   = 9'b010101001;

  // Expected control outputs after edge k for stability count n and m sync M-cycles.
  function automatic logic [4:0] exp_ctrl(int k, int n, int m);
    logic osc_ena, osc_stable, clk_ena, sync_rel;
    osc_ena    = (k >= 1);
    osc_stable = (k >= 1 + n);
    clk_ena    = (k >= 2 + n);
    sync_rel   = (k >= 2 + n + 8 * m);
    return {osc_ena, osc_stable, ~osc_stable, clk_ena, ~sync_rel};
  endfunction

  // Expected phase outputs after edge k; patterns listed ph0 first (MSB).
  function automatic logic [8:0] exp_phs(int k, int n);
    logic [7:0] pat_adr, pat_data, pat_inc, pat_latch, pat_main;
    int ph;
    logic a, d, i, l, mn;
    pat_adr   = 8'b11110000;
    pat_data  = 8'b00111100;
    pat_inc   = 8'b00001111;
    pat_latch = 8'b00000001;
    pat_main  = 8'b10101010;
    if (k < 2 + n) return PhsIdle;
    ph = (k - 2 - n) % 8;
    a  = pat_adr[7-ph];
    d  = pat_data[7-ph];
    i  = pat_inc[7-ph];
    l  = pat_latch[7-ph];
    mn = pat_main[7-ph];
    return {a, ~a, d, ~d, i, ~i, l, mn, ~mn};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    repeat (8) step();
    n_checks++;
    if (ctrl_a !== CtrlReset) $display("FAIL reset_ctrl_a: got %b want %b", ctrl_a, CtrlReset);
    else n_pass++;
    n_checks++;
    if (phs_a !== PhsIdle) $display("FAIL reset_phs_a: got %b want %b", phs_a, PhsIdle);
    else n_pass++;
    n_checks++;
    if (ctrl_b !== CtrlReset) $display("FAIL reset_ctrl_b: got %b want %b", ctrl_b, CtrlReset);
    else n_pass++;
    n_checks++;
    if (phs_b !== PhsIdle) $display("FAIL reset_phs_b: got %b want %b", phs_b, PhsIdle);
    else n_pass++;
  endtask

  task automatic test_startup();
    RESET = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      step();
      n_checks++;
      if (ctrl_a !== exp_ctrl(k, 16, 2))
        $display("FAIL startup_ctrl_a k=%0d: got %b want %b", k, ctrl_a, exp_ctrl(k, 16, 2));
      else n_pass++;
      n_checks++;
      if (ctrl_b !== exp_ctrl(k, 1, 1))
        $display("FAIL startup_ctrl_b k=%0d: got %b want %b", k, ctrl_b, exp_ctrl(k, 1, 1));
      else n_pass++;
      n_checks++;
      if (phs_a !== exp_phs(k, 16))
        $display("FAIL startup_phs_a k=%0d: got %b want %b", k, phs_a, exp_phs(k, 16));
      else n_pass++;
      n_checks++;
      if (phs_b !== exp_phs(k, 1))
        $display("FAIL startup_phs_b k=%0d: got %b want %b", k, phs_b, exp_phs(k, 1));
      else n_pass++;
    end
  endtask

  task automatic test_phases();
    for (int k = 41; k <= 296; k++) begin
      step();
      n_checks++;
      if (phs_a !== exp_phs(k, 16) || ctrl_a !== exp_ctrl(k, 16, 2))
        $display("FAIL phases_a k=%0d: got %b/%b want %b/%b", k, phs_a, ctrl_a,
                 exp_phs(k, 16), exp_ctrl(k, 16, 2));
      else n_pass++;
      n_checks++;
      if (phs_b !== exp_phs(k, 1) || ctrl_b !== exp_ctrl(k, 1, 1))
        $display("FAIL phases_b k=%0d: got %b/%b want %b/%b", k, phs_b, ctrl_b,
                 exp_phs(k, 1), exp_ctrl(k, 1, 1));
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    RESET = 1'b0;
    step();
    RESET = 1'b1;
    n_checks++;
    if (ctrl_a !== CtrlReset || phs_a !== PhsIdle)
      $display("FAIL midreset_a: got %b/%b want %b/%b", ctrl_a, phs_a, CtrlReset, PhsIdle);
    else n_pass++;
    n_checks++;
    if (ctrl_b !== CtrlReset || phs_b !== PhsIdle)
      $display("FAIL midreset_b: got %b/%b want %b/%b", ctrl_b, phs_b, CtrlReset, PhsIdle);
    else n_pass++;
    for (int k = 0; k <= 40; k++) begin
      step();
      n_checks++;
      if (ctrl_a !== exp_ctrl(k, 16, 2) || phs_a !== exp_phs(k, 16))
        $display("FAIL restart_a k=%0d: got %b/%b want %b/%b", k, ctrl_a, phs_a,
                 exp_ctrl(k, 16, 2), exp_phs(k, 16));
      else n_pass++;
      n_checks++;
      if (ctrl_b !== exp_ctrl(k, 1, 1) || phs_b !== exp_phs(k, 1))
        $display("FAIL restart_b k=%0d: got %b/%b want %b/%b", k, ctrl_b, phs_b,
                 exp_ctrl(k, 1, 1), exp_phs(k, 1));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_phases();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
